jpeg_cone_pipe: RTL and testbench

//  Parametrised, pipelined successor of the single-bit NAND/NOR/INV -> AOI21 timing cone.

---
 rtl/jpeg_cone_pipe.sv | 154 +++++++++++++++
 tb/tb_jpeg_cone_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_cone_pipe.sv
// Elastic pipelined NAND/NOR/INV -> AOI21/AO21 cone over WIDTH lanes, with per-beat
// popcount and an output-handshake beat counter.
module jpeg_cone_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           mode,
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    input  logic [WIDTH-1:0]               c,
    input  logic [WIDTH-1:0]               d,
    input  logic [WIDTH-1:0]               e,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               y,
    output logic [$clog2(WIDTH+1)-1:0]     y_ones,
    output logic [CNT_W-1:0]               beat_cnt,
    output logic                           cnt_wrap
);
    localparam int ONES_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  p_in, q_in, r_in;
    logic [WIDTH-1:0]  fin_p, fin_q, fin_r;
    logic              fin_m;
    logic [STAGES-1:0] v_q, v_d, ld;
    logic [STAGES:0]   v_chain;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              cnt_wrap_q, cnt_wrap_d;
    logic              out_hs;

    function automatic logic [WIDTH-1:0] cone_f(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] r,
                                                input logic             m);
        logic [WIDTH-1:0] ao;
        ao = (p & q) | r;
        return m ? ao : ~ao;
    endfunction

    function automatic logic [ONES_W-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [ONES_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) sum = sum + ONES_W'(v[i]);
        return sum;
    endfunction

    assign p_in = ~(a & b);
    assign q_in = ~(c | d);
    assign r_in = ~e;

    // A stage may load when empty or when everything downstream of it can move.
    always_comb begin
        logic nxt;
        nxt = out_ready;
        ld  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = ~v_q[k] | nxt;
            nxt   = ld[k];
        end
    end

    assign v_chain = {v_q, in_valid};
    assign v_d     = (v_chain[STAGES-1:0] & ld) | (v_q & ~ld);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_q <= '0;
        else     v_q <= v_d;
    end

    generate
        if (STAGES == 1) begin : g_one
            assign fin_p = p_in;
            assign fin_q = q_in;
            assign fin_r = r_in;
            assign fin_m = mode;
        end else begin : g_multi
            for (genvar k = 0; k < STAGES - 1; k++) begin : g_reg
                logic [WIDTH-1:0] p_q, q_q, r_q;
                logic             m_q;
                logic [WIDTH-1:0] p_d, q_d, r_d;
                logic             m_d;
                if (k == 0) begin : g_src
                    assign p_d = p_in;
                    assign q_d = q_in;
                    assign r_d = r_in;
                    assign m_d = mode;
                end else begin : g_src
                    assign p_d = g_reg[k-1].p_q;
                    assign q_d = g_reg[k-1].q_q;
                    assign r_d = g_reg[k-1].r_q;
                    assign m_d = g_reg[k-1].m_q;
                end
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        p_q <= '0;
                        q_q <= '0;
                        r_q <= '0;
                        m_q <= 1'b0;
                    end else if (ld[k]) begin
                        p_q <= p_d;
                        q_q <= q_d;
                        r_q <= r_d;
                        m_q <= m_d;
                    end
                end
            end
            assign fin_p = g_reg[STAGES-2].p_q;
            assign fin_q = g_reg[STAGES-2].q_q;
            assign fin_r = g_reg[STAGES-2].r_q;
            assign fin_m = g_reg[STAGES-2].m_q;
        end
    endgenerate

    assign y_d    = cone_f(fin_p, fin_q, fin_r, fin_m);
    assign ones_d = popcnt(y_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            ones_q <= '0;
        end else if (ld[STAGES-1]) begin
            y_q    <= y_d;
            ones_q <= ones_d;
        end
    end

    assign out_hs     = v_q[STAGES-1] & out_ready;
    assign beat_cnt_d = out_hs ? beat_cnt_q + CNT_W'(1) : beat_cnt_q;
    assign cnt_wrap_d = out_hs & (&beat_cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
            cnt_wrap_q <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            cnt_wrap_q <= cnt_wrap_d;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[STAGES-1];
    assign y         = y_q;
    assign y_ones    = ones_q;
    assign beat_cnt  = beat_cnt_q;
    assign cnt_wrap  = cnt_wrap_q;
endmodule

// File: tb/tb_jpeg_cone_pipe.sv
// Scoreboard bench for jpeg_cone_pipe: three instances (STAGES 2/4/1, CNT_W 16/4/16),
// a single driver process and a single negedge monitor that owns all comparisons.
module tb_jpeg_cone_pipe;
    localparam int ST[3]   = '{2, 4, 1};
    localparam int CMAX[3] = '{65535, 15, 65535};

    localparam logic [7:0] TA[10] = '{8'h0F, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hAA, 8'hAA, 8'h33};
    localparam logic [7:0] TB[10] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hCC, 8'hCC, 8'h55};
    localparam logic [7:0] TC[10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'h0C};
    localparam logic [7:0] TD[10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h30};
    localparam logic [7:0] TE[10] = '{8'hFF, 8'hFF, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h0F};
    localparam logic       TM[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] TY[10] = '{8'h0F, 8'hF0, 8'hA5, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hF8, 8'h07, 8'h0D};
    localparam logic [3:0] TO[10] = '{4'd4, 4'd4, 4'd4, 4'd0, 4'd8, 4'd0, 4'd8, 4'd5, 4'd3, 4'd3};

    typedef struct {
        logic [7:0] y;
        logic [3:0] ones;
        int         cyc;
        bit         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]      iv_r, md_r, or_r;
    logic [2:0][7:0] a_r, b_r, c_r, d_r, e_r;
    wire  [2:0]      ir_w, ov_w, wr_w;
    wire  [2:0][7:0] y_w;
    wire  [2:0][3:0] on_w;
    wire  [2:0][15:0] cnt_w;
    assign cnt_w[1][15:4] = '0;

    int   or_mode[3];
    int   st_lo, st_hi;
    int   cyc;
    int   n_chk, n_fail;
    exp_t sb_q[3][$];
    int   m_cnt[3];
    bit   m_wrap[3];
    bit   held_v[3];
    logic [7:0] held_y[3];
    logic [3:0] held_o[3];

    jpeg_cone_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv_r[0]), .in_ready(ir_w[0]), .mode(md_r[0]),
        .a(a_r[0]), .b(b_r[0]), .c(c_r[0]), .d(d_r[0]), .e(e_r[0]),
        .out_valid(ov_w[0]), .out_ready(or_r[0]), .y(y_w[0]), .y_ones(on_w[0]),
        .beat_cnt(cnt_w[0]), .cnt_wrap(wr_w[0]));

    jpeg_cone_pipe #(.WIDTH(8), .STAGES(4), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv_r[1]), .in_ready(ir_w[1]), .mode(md_r[1]),
        .a(a_r[1]), .b(b_r[1]), .c(c_r[1]), .d(d_r[1]), .e(e_r[1]),
        .out_valid(ov_w[1]), .out_ready(or_r[1]), .y(y_w[1]), .y_ones(on_w[1]),
        .beat_cnt(cnt_w[1][3:0]), .cnt_wrap(wr_w[1]));

    jpeg_cone_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv_r[2]), .in_ready(ir_w[2]), .mode(md_r[2]),
        .a(a_r[2]), .b(b_r[2]), .c(c_r[2]), .d(d_r[2]), .e(e_r[2]),
        .out_valid(ov_w[2]), .out_ready(or_r[2]), .y(y_w[2]), .y_ones(on_w[2]),
        .beat_cnt(cnt_w[2]), .cnt_wrap(wr_w[2]));

    // Bit-at-a-time reference of the cone.
    function automatic logic [7:0] ref_y(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                         input logic [7:0] d, input logic [7:0] e, input logic m);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) begin
            logic pj, qj, rj, oj;
            pj = !(a[j] && b[j]);
            qj = !(c[j] || d[j]);
            rj = !e[j];
            oj = (pj && qj) || rj;
            r[j] = m ? oj : !oj;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_ones(input logic [7:0] v);
        int n;
        n = 0;
        for (int j = 0; j < 8; j++) if (v[j]) n++;
        return 4'(n);
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual=%0h required=%0h (t=%0t)", nm, i, act, req, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                chk("rst_out_valid", i, ov_w[i], 0);
                chk("rst_y", i, y_w[i], 0);
                chk("rst_y_ones", i, on_w[i], 0);
                chk("rst_beat_cnt", i, cnt_w[i], 0);
                chk("rst_cnt_wrap", i, wr_w[i], 0);
                sb_q[i].delete();
                m_cnt[i]  = 0;
                m_wrap[i] = 1'b0;
                held_v[i] = 1'b0;
            end else begin
                bit hs;
                chk("beat_cnt", i, cnt_w[i], m_cnt[i]);
                chk("cnt_wrap", i, wr_w[i], m_wrap[i]);
                chk("in_ready", i, ir_w[i], (sb_q[i].size() < ST[i]) || or_r[i]);
                if (held_v[i] && ov_w[i]) begin
                    chk("stall_y_stable", i, y_w[i], held_y[i]);
                    chk("stall_ones_stable", i, on_w[i], held_o[i]);
                end
                if (sb_q[i].size() == 0) chk("no_stale_beat", i, ov_w[i], 0);
                hs = ov_w[i] && or_r[i];
                if (hs && sb_q[i].size() != 0) begin
                    exp_t ex;
                    ex = sb_q[i].pop_front();
                    chk("y", i, y_w[i], ex.y);
                    chk("y_ones", i, on_w[i], ex.ones);
                    if (ex.lat) chk("latency", i, cyc - ex.cyc, ST[i]);
                end
                m_wrap[i] = hs && (m_cnt[i] == CMAX[i]);
                if (hs) m_cnt[i] = (m_cnt[i] == CMAX[i]) ? 0 : m_cnt[i] + 1;
                held_v[i] = ov_w[i] && !or_r[i];
                held_y[i] = y_w[i];
                held_o[i] = on_w[i];
            end
        end
    end

    // out_ready driver: 0 always ready, 1 random, 2 stall window, 3 held low
    initial begin
        or_r = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                case (or_mode[i])
                    0:       or_r[i] = 1'b1;
                    1:       or_r[i] = ($urandom_range(0, 3) != 0);
                    2:       or_r[i] = !(cyc >= st_lo && cyc <= st_hi);
                    default: or_r[i] = 1'b0;
                endcase
            end
        end
    end

    task automatic send(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic [7:0] e, input logic m,
                        input logic [7:0] ey, input logic [3:0] eo, input bit lat);
        int t;
        a_r[i] = a; b_r[i] = b; c_r[i] = c; d_r[i] = d; e_r[i] = e; md_r[i] = m;
        iv_r[i] = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            #1;
            if (ir_w[i]) break;
            t++;
            if (t > 500) begin
                $display("FAIL in_handshake_timeout dut%0d: in_ready stuck low", i);
                $fatal(1, "input handshake timeout");
            end
        end
        sb_q[i].push_back('{y: ey, ones: eo, cyc: cyc, lat: lat});
        @(posedge clk);
        #1;
        iv_r[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q[0].size() + sb_q[1].size() + sb_q[2].size() != 0) begin
            idle(1);
            t++;
            if (t > 2000) begin
                $display("FAIL drain_timeout: beats still pending");
                $fatal(1, "drain timeout");
            end
        end
        idle(3);
    endtask

    task automatic rand_run(input int i, input int n);
        logic [7:0] a, b, c, d, e, ey;
        logic       m;
        or_mode[i] = 1;
        for (int k = 0; k < n; k++) begin
            idle($urandom_range(0, 2));
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            d = 8'($urandom); e = 8'($urandom); m = 1'($urandom);
            ey = ref_y(a, b, c, d, e, m);
            send(i, a, b, c, d, e, m, ey, ref_ones(ey), 1'b0);
        end
        drain();
        or_mode[i] = 0;
        idle(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        iv_r = '0; md_r = '0;
        a_r = '0; b_r = '0; c_r = '0; d_r = '0; e_r = '0;
        for (int i = 0; i < 3; i++) or_mode[i] = 0;
        st_lo = 0; st_hi = -1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // isolated beats: value and exact latency
        for (int k = 0; k < 10; k++) begin
            send(0, TA[k], TB[k], TC[k], TD[k], TE[k], TM[k], TY[k], TO[k], 1'b1);
            idle(4);
        end
        drain();

        // 10-beat stream with a 4-cycle downstream stall
        st_lo = cyc + 3;
        st_hi = cyc + 6;
        or_mode[0] = 2;
        for (int k = 0; k < 10; k++)
            send(0, TA[k], TB[k], TC[k], TD[k], TE[k], TM[k], TY[k], TO[k], 1'b0);
        drain();
        or_mode[0] = 0;

        // reset with two beats held in the pipe
        or_mode[0] = 3;
        idle(2);
        send(0, TA[0], TB[0], TC[0], TD[0], TE[0], TM[0], TY[0], TO[0], 1'b0);
        send(0, TA[2], TB[2], TC[2], TD[2], TE[2], TM[2], TY[2], TO[2], 1'b0);
        #1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        or_mode[0] = 0;
        idle(8);

        rand_run(0, 20);
        rand_run(1, 40);
        rand_run(2, 40);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
